wb_xfer_bridge: RTL

WB_XFER_BRIDGE -- requirements
Module: wb_xfer_bridge

---
 rtl/wb_xfer_bridge.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/wb_xfer_bridge.sv
// Single-outstanding Wishbone bridge from the I2C-side master to the SPI core.
// It validates the address range, enforces a downstream timeout, and counts error terminations.
module wb_xfer_bridge #(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned NUM_REGS = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       s_cyc_i,
  input  logic       s_stb_i,
  input  logic       s_we_i,
  input  logic [7:0] s_adr_i,
  input  logic [7:0] s_dat_i,
  output logic [7:0] s_dat_o,
  output logic       s_ack_o,
  output logic       s_err_o,
  output logic       m_cyc_o,
  output logic       m_stb_o,
  output logic       m_we_o,
  output logic [7:0] m_adr_o,
  output logic [7:0] m_dat_o,
  input  logic [7:0] m_dat_i,
  input  logic       m_ack_i,
  output logic       busy_o,
  output logic [7:0] err_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [8:0]  NUM_REGS_W = 9'(NUM_REGS);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

  state_t      st_r, nxt_st_s;
  logic        nxt_err_s;
  logic [15:0] tmo_cnt_r, nxt_tmo_s;
  logic [7:0]  adr_r, nxt_adr_s, dat_r, nxt_dat_s;
  logic        we_r, nxt_we_s;
  logic [7:0]  s_dat_r, nxt_s_dat_s, err_cnt_r, nxt_err_cnt_s;
  logic        s_ack_r, nxt_s_ack_s, s_err_r, nxt_s_err_s;
  logic        m_cyc_r, nxt_m_cyc_s, busy_r, nxt_busy_s;

  // State and registered-output update; reset clears everything asynchronously.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      st_r      <= ST_IDLE;
      tmo_cnt_r <= 16'd0;
      adr_r     <= 8'h00;
      dat_r     <= 8'h00;
      we_r      <= 1'b0;
      s_dat_r   <= 8'h00;
      err_cnt_r <= 8'h00;
      s_ack_r   <= 1'b0;
      s_err_r   <= 1'b0;
      m_cyc_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      st_r      <= nxt_st_s;
      tmo_cnt_r <= nxt_tmo_s;
      adr_r     <= nxt_adr_s;
      dat_r     <= nxt_dat_s;
      we_r      <= nxt_we_s;
      s_dat_r   <= nxt_s_dat_s;
      err_cnt_r <= nxt_err_cnt_s;
      s_ack_r   <= nxt_s_ack_s;
      s_err_r   <= nxt_s_err_s;
      m_cyc_r   <= nxt_m_cyc_s;
      busy_r    <= nxt_busy_s;
    end
  end

  // Next-state logic; an upstream abort outranks ack, and ack outranks timeout.
  always_comb begin
    nxt_st_s  = st_r;
    nxt_err_s = 1'b0;
    case (st_r)
      ST_IDLE: begin
        if (s_cyc_i && s_stb_i) begin
          if ({1'b0, s_adr_i} < NUM_REGS_W) begin
            nxt_st_s = ST_ISSUE;
          end else begin
            nxt_st_s  = ST_RESP;
            nxt_err_s = 1'b1;
          end
        end else begin
          nxt_st_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!s_cyc_i) begin
          nxt_st_s = ST_IDLE;
        end else if (m_ack_i) begin
          nxt_st_s = ST_RESP;
        end else if (tmo_cnt_r == TMO_LAST) begin
          nxt_st_s  = ST_RESP;
          nxt_err_s = 1'b1;
        end else begin
          nxt_st_s = ST_ISSUE;
        end
      end
      ST_RESP: nxt_st_s = ST_RELEASE;
      ST_RELEASE: begin
        if (!s_stb_i) begin
          nxt_st_s = ST_IDLE;
        end else begin
          nxt_st_s = ST_RELEASE;
        end
      end
      default: nxt_st_s = ST_IDLE;
    endcase
  end

  // Output and datapath logic, computed from the upcoming state so every output is a flop.
  always_comb begin
    nxt_m_cyc_s = (nxt_st_s == ST_ISSUE);
    nxt_busy_s  = (nxt_st_s != ST_IDLE);
    nxt_s_ack_s = (nxt_st_s == ST_RESP) && !nxt_err_s;
    nxt_s_err_s = (nxt_st_s == ST_RESP) && nxt_err_s;
    if (st_r == ST_ISSUE) begin
      nxt_tmo_s = tmo_cnt_r + 16'd1;
    end else begin
      nxt_tmo_s = 16'd0;
    end
    if ((st_r == ST_IDLE) && s_cyc_i && s_stb_i) begin
      nxt_adr_s = s_adr_i;
      nxt_dat_s = s_dat_i;
      nxt_we_s  = s_we_i;
    end else begin
      nxt_adr_s = adr_r;
      nxt_dat_s = dat_r;
      nxt_we_s  = we_r;
    end
    if (nxt_s_err_s) begin
      nxt_s_dat_s = 8'h00;
    end else if (nxt_s_ack_s && !we_r) begin
      nxt_s_dat_s = m_dat_i;
    end else begin
      nxt_s_dat_s = s_dat_r;
    end
    if (nxt_s_err_s && (err_cnt_r != 8'hFF)) begin
      nxt_err_cnt_s = err_cnt_r + 8'd1;
    end else begin
      nxt_err_cnt_s = err_cnt_r;
    end
  end

  assign s_dat_o   = s_dat_r;
  assign s_ack_o   = s_ack_r;
  assign s_err_o   = s_err_r;
  assign m_cyc_o   = m_cyc_r;
  assign m_stb_o   = m_cyc_r;
  assign m_we_o    = we_r;
  assign m_adr_o   = adr_r;
  assign m_dat_o   = dat_r;
  assign busy_o    = busy_r;
  assign err_cnt_o = err_cnt_r;

endmodule
